// File: rtl/probe_rle_pkg.sv
// probe_rle_pkg
// Shared constants, byte-format helpers and the encoder action type for the
// saxoscope probe run-length encoder.
//   RUN_FLAG   : bit pattern marking a run byte (bit 7 set)
//   MAX_RUN    : longest run a single run byte can describe
//   RUN_LIMIT  : count register value at which a full run byte is flushed
//   act_e      : what the encoder wants to do in the current cycle
//   mk_sample  : build a sample byte from a (zero-extended) probe value
//   mk_run     : build a run byte from a run length
package probe_rle_pkg;

  localparam logic [7:0] RUN_FLAG  = 8'h80;
  localparam logic [6:0] MAX_RUN   = 7'd127;
  // The count register holds "further clocks minus one" at the moment of the
  // flush, so 126 in the register becomes a run byte of 127.
  localparam logic [6:0] RUN_LIMIT = 7'd126;

  typedef enum logic [2:0] {
    ACT_IDLE       = 3'd0,  // capture disabled, run state held cleared
    ACT_SAMPLE     = 3'd1,  // push a single sample byte
    ACT_RUN_SAMPLE = 3'd2,  // push run byte then sample byte, same cycle
    ACT_RUN_MAX    = 3'd3,  // push a full-length run byte (8'hFF)
    ACT_COUNT      = 3'd4   // extend the current run, no push
  } act_e;

  function automatic logic [7:0] mk_sample(input logic [6:0] value);
    return {1'b0, value};
  endfunction

  function automatic logic [7:0] mk_run(input logic [6:0] n);
    return RUN_FLAG | {1'b0, n};
  endfunction

endpackage

// File: rtl/probe_rle_encoder_byte_queue.sv
// byte_queue
// Small circular byte buffer between the encoder and the FIFO4 write port.
// Accepts 0, 1 or 2 ordered pushes and at most one pop per clock.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   push_count [1:0]  : number of bytes to push this cycle (0..2)
//   push_data0 [7:0]  : first byte pushed (lands nearest the head)
//   push_data1 [7:0]  : second byte pushed, only used when push_count == 2
//   pop               : consume the head byte (ignored when empty)
//   head [7:0]        : current head byte, 8'h00 when empty
//   empty             : queue holds no bytes
//   free_slots        : number of unused entries before this cycle's pop
module byte_queue #(
  parameter int QUEUE_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            push_count,
  input  logic [7:0]            push_data0,
  input  logic [7:0]            push_data1,
  input  logic                  pop,
  output logic [7:0]            head,
  output logic                  empty,
  output logic [QUEUE_LOG2:0]   free_slots
);

  localparam int DEPTH = 1 << QUEUE_LOG2;

  logic [7:0]              mem_r [DEPTH];
  // One extra pointer bit separates "full" from "empty" when the indices match.
  logic [QUEUE_LOG2:0]     wr_ptr_r;
  logic [QUEUE_LOG2:0]     rd_ptr_r;
  logic [QUEUE_LOG2:0]     used_s;
  logic [QUEUE_LOG2:0]     wr_step_s;
  logic [QUEUE_LOG2-1:0]   wr_idx0_s;
  logic [QUEUE_LOG2-1:0]   wr_idx1_s;
  logic [QUEUE_LOG2-1:0]   rd_idx_s;
  logic                    pop_s;

  assign used_s     = wr_ptr_r - rd_ptr_r;
  assign empty      = (used_s == (QUEUE_LOG2+1)'(0));
  assign free_slots = (QUEUE_LOG2+1)'(DEPTH) - used_s;
  assign wr_idx0_s  = wr_ptr_r[QUEUE_LOG2-1:0];
  assign wr_idx1_s  = wr_idx0_s + QUEUE_LOG2'(1);
  assign rd_idx_s   = rd_ptr_r[QUEUE_LOG2-1:0];
  assign pop_s      = pop & ~empty;

  // Translate the push request into a pointer advance; illegal counts push nothing.
  always_comb begin
    wr_step_s = (QUEUE_LOG2+1)'(0);
    case (push_count)
      2'd1:    wr_step_s = (QUEUE_LOG2+1)'(1);
      2'd2:    wr_step_s = (QUEUE_LOG2+1)'(2);
      default: wr_step_s = (QUEUE_LOG2+1)'(0);
    endcase
  end

  // Head byte presented to the FIFO; forced to zero while the queue is empty.
  always_comb begin
    head = 8'h00;
    if (empty) begin
      head = 8'h00;
    end else begin
      head = mem_r[rd_idx_s];
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= (QUEUE_LOG2+1)'(0);
      rd_ptr_r <= (QUEUE_LOG2+1)'(0);
    end else begin
      case (push_count)
        2'd1: begin
          mem_r[wr_idx0_s] <= push_data0;
        end
        2'd2: begin
          mem_r[wr_idx0_s] <= push_data0;
          mem_r[wr_idx1_s] <= push_data1;
        end
        default: begin
        end
      endcase
      wr_ptr_r <= wr_ptr_r + wr_step_s;
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (QUEUE_LOG2+1)'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

endmodule

// File: rtl/probe_rle_encoder.sv
// probe_rle_encoder
// Run-length compressor for the saxoscope probe stream. Emits a sample byte
// on every probe change and a run byte describing how long the previous
// value held, through a small queue that absorbs double-byte bursts and
// FIFO-full stalls. Dropped groups set a sticky overflow flag.
// Ports:
//   clk          : FIFO_clk, the only clock
//   reset        : synchronous active-high reset
//   enable       : capture enable; low holds run state cleared
//   probe        : synchronized probe sample, PROBE_WIDTH bits
//   fifo_ready   : FIFO4 can accept a byte this clock
//   out_data     : byte presented to FIFO4 (queue head, 8'h00 when empty)
//   out_write    : FIFO4 write strobe, fifo_ready & ~queue_empty
//   overflow     : sticky lost-byte flag, cleared only by reset
module probe_rle_encoder
  import probe_rle_pkg::*;
#(
  parameter int PROBE_WIDTH = 5,
  parameter int QUEUE_LOG2  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [PROBE_WIDTH-1:0] probe,
  input  logic                   fifo_ready,
  output logic [7:0]             out_data,
  output logic                   out_write,
  output logic                   overflow
);

  logic [PROBE_WIDTH-1:0] last_r;
  logic [PROBE_WIDTH-1:0] last_nxt_s;
  logic [6:0]             count_r;
  logic [6:0]             count_nxt_s;
  logic                   force_r;
  logic                   force_nxt_s;
  logic                   overflow_r;
  logic                   overflow_nxt_s;

  act_e                   act_s;
  logic [1:0]             need_s;
  logic                   drop_s;
  logic [1:0]             push_count_s;
  logic [7:0]             push_data0_s;
  logic [7:0]             push_data1_s;
  logic [6:0]             probe_ext_s;

  logic [QUEUE_LOG2:0]    free_slots_s;
  logic [QUEUE_LOG2:0]    free_after_s;
  logic                   queue_empty_s;
  logic [7:0]             head_s;
  logic                   pop_s;

  byte_queue #(
    .QUEUE_LOG2 (QUEUE_LOG2)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push_count (push_count_s),
    .push_data0 (push_data0_s),
    .push_data1 (push_data1_s),
    .pop        (pop_s),
    .head       (head_s),
    .empty      (queue_empty_s),
    .free_slots (free_slots_s)
  );

  assign probe_ext_s  = 7'(probe);
  assign pop_s        = fifo_ready & ~queue_empty_s;
  // A same-cycle pop frees its slot before the pushes are judged.
  assign free_after_s = free_slots_s + (QUEUE_LOG2+1)'(pop_s);

  assign out_write = pop_s;
  assign out_data  = head_s;
  assign overflow  = overflow_r;

  // Classify this cycle's encoder action and how many bytes it needs.
  always_comb begin
    act_s  = ACT_IDLE;
    need_s = 2'd0;
    if (!enable) begin
      act_s  = ACT_IDLE;
      need_s = 2'd0;
    end else if (force_r) begin
      act_s  = ACT_SAMPLE;
      need_s = 2'd1;
    end else if (probe != last_r) begin
      if (count_r != 7'd0) begin
        act_s  = ACT_RUN_SAMPLE;
        need_s = 2'd2;
      end else begin
        act_s  = ACT_SAMPLE;
        need_s = 2'd1;
      end
    end else if (count_r == RUN_LIMIT) begin
      act_s  = ACT_RUN_MAX;
      need_s = 2'd1;
    end else begin
      act_s  = ACT_COUNT;
      need_s = 2'd0;
    end
  end

  // A group is dropped whole when it does not fit after this cycle's pop.
  always_comb begin
    drop_s = 1'b0;
    if ((QUEUE_LOG2+1)'(need_s) > free_after_s) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
  end

  // Next encoder state and queue push group for the chosen action.
  always_comb begin
    last_nxt_s     = last_r;
    count_nxt_s    = count_r;
    force_nxt_s    = force_r;
    overflow_nxt_s = overflow_r;
    push_data0_s   = 8'h00;
    push_data1_s   = 8'h00;
    push_count_s   = 2'd0;
    case (act_s)
      ACT_SAMPLE: begin
        push_data0_s = mk_sample(probe_ext_s);
        last_nxt_s   = probe;
        count_nxt_s  = 7'd0;
        force_nxt_s  = 1'b0;
      end
      ACT_RUN_SAMPLE: begin
        push_data0_s = mk_run(count_r);
        push_data1_s = mk_sample(probe_ext_s);
        last_nxt_s   = probe;
        count_nxt_s  = 7'd0;
      end
      ACT_RUN_MAX: begin
        push_data0_s = mk_run(MAX_RUN);
        count_nxt_s  = 7'd0;
      end
      ACT_COUNT: begin
        count_nxt_s = count_r + 7'd1;
      end
      ACT_IDLE: begin
        // Any pending run is abandoned; the next enabled cycle re-samples.
        force_nxt_s = 1'b1;
        count_nxt_s = 7'd0;
      end
      default: begin
        force_nxt_s = 1'b1;
        count_nxt_s = 7'd0;
      end
    endcase
    if (drop_s) begin
      // Nothing of the group is queued; resynchronise with a fresh sample.
      push_count_s   = 2'd0;
      overflow_nxt_s = 1'b1;
      force_nxt_s    = 1'b1;
      count_nxt_s    = 7'd0;
      last_nxt_s     = last_r;
    end else begin
      push_count_s = need_s;
    end
  end

  // Encoder state and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_r     <= '0;
      count_r    <= 7'd0;
      force_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      last_r     <= last_nxt_s;
      count_r    <= count_nxt_s;
      force_r    <= force_nxt_s;
      overflow_r <= overflow_nxt_s;
    end
  end

endmodule

// File: tb/tb_probe_rle_encoder.sv
// tb_probe_rle_encoder
// Self-checking bench for probe_rle_encoder: a cycle table, hand-written
// corner-case sequences, and randomized traffic, all compared every cycle
// against a queue-based reference model of the byte stream.
module tb_probe_rle_encoder;

  localparam int PW    = 5;
  localparam int QL    = 2;
  localparam int DEPTH = 1 << QL;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [PW-1:0] probe;
  logic          fifo_ready;
  logic [7:0]    out_data;
  logic          out_write;
  logic          overflow;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0]    mq[$];
  logic [PW-1:0] m_last;
  int            m_count;
  bit            m_force;
  bit            m_ovf;

  // Bytes actually written by the DUT, and expected lists
  logic [7:0]    got[$];
  logic [7:0]    expq[$];

  typedef struct {
    logic          rst;
    logic          en;
    logic [PW-1:0] pr;
    logic          rdy;
    logic          exp_w;
    logic [7:0]    exp_d;
    logic          exp_o;
  } vec_t;

  vec_t tbl[11];

  probe_rle_encoder #(
    .PROBE_WIDTH (PW),
    .QUEUE_LOG2  (QL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .probe      (probe),
    .fifo_ready (fifo_ready),
    .out_data   (out_data),
    .out_write  (out_write),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model: pop, then build the byte group the rules call for,
  // then accept it whole or drop it whole.
  task automatic model_step();
    logic [7:0]    grp[$];
    logic [PW-1:0] nl;
    int            nc;
    if (reset) begin
      mq.delete();
      m_last = '0; m_count = 0; m_force = 1'b1; m_ovf = 1'b0;
      return;
    end
    if (fifo_ready && mq.size() > 0) void'(mq.pop_front());
    if (!enable) begin
      m_force = 1'b1; m_count = 0;
      return;
    end
    nl = m_last; nc = m_count;
    if (m_force) begin
      grp.push_back(8'(probe)); nl = probe; nc = 0;
    end else if (probe != m_last) begin
      if (m_count > 0) grp.push_back(8'(128 + m_count));
      grp.push_back(8'(probe)); nl = probe; nc = 0;
    end else if (m_count == 126) begin
      grp.push_back(8'hFF); nc = 0;
    end else begin
      nc = m_count + 1;
    end
    if (grp.size() > DEPTH - mq.size()) begin
      m_ovf = 1'b1; m_force = 1'b1; m_count = 0;
    end else begin
      foreach (grp[i]) mq.push_back(grp[i]);
      m_last = nl; m_count = nc; m_force = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic       ew;
    logic [7:0] ed;
    ew = fifo_ready && (mq.size() > 0);
    ed = (mq.size() > 0) ? mq[0] : 8'h00;
    chk("out_write", 32'(out_write), 32'(ew));
    chk("out_data",  32'(out_data),  32'(ed));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    if (out_write === 1'b1) got.push_back(out_data);
  endtask

  task automatic cyc(input logic r, input logic e, input logic [PW-1:0] p, input logic y);
    reset = r; enable = e; probe = p; fifo_ready = y;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_got(input string name);
    chk({name, "_len"}, 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      chk($sformatf("%s_byte%0d", name, i),
          (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(expq[i]));
    end
  endtask

  initial begin
    m_last = '0; m_count = 0; m_force = 1'b1; m_ovf = 1'b0;

    // Probe 05 for four clocks then 06, FIFO stalled, then drained.
    tbl[0]  = '{1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 5'h05, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 5'h05, 1'b0, 1'b0, 8'h05, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 5'h05, 1'b0, 1'b0, 8'h05, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 5'h05, 1'b0, 1'b0, 8'h05, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 5'h06, 1'b0, 1'b0, 8'h05, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 5'h06, 1'b1, 1'b1, 8'h05, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 5'h06, 1'b1, 1'b1, 8'h83, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 5'h06, 1'b1, 1'b1, 8'h06, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 5'h06, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 5'h06, 1'b1, 1'b0, 8'h00, 1'b0};

    cyc(1'b1, 1'b0, 5'h00, 1'b0);
    chk("reset_write", 32'(out_write), 32'h0);
    chk("reset_data",  32'(out_data),  32'h0);
    chk("reset_ovf",   32'(overflow),  32'h0);

    for (int i = 0; i < 11; i++) begin
      reset = tbl[i].rst; enable = tbl[i].en; probe = tbl[i].pr; fifo_ready = tbl[i].rdy;
      @(negedge clk);
      check_outputs();
      chk($sformatf("tbl%0d_write", i), 32'(out_write), 32'(tbl[i].exp_w));
      chk($sformatf("tbl%0d_data", i),  32'(out_data),  32'(tbl[i].exp_d));
      chk($sformatf("tbl%0d_ovf", i),   32'(overflow),  32'(tbl[i].exp_o));
      @(posedge clk);
      model_step();
      #1;
    end

    // Long run: 300 clocks of 03 then 04.
    cyc(1'b1, 1'b0, 5'h00, 1'b1);
    got.delete();
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 5'h03, 1'b1);
    for (int i = 0; i < 5; i++)   cyc(1'b0, 1'b1, 5'h04, 1'b1);
    expq = '{8'h03, 8'hFF, 8'hFF, 8'hAD, 8'h04};
    check_got("longrun");
    chk("longrun_ovf", 32'(overflow), 32'h0);

    // Alternating samples, no run bytes.
    cyc(1'b1, 1'b0, 5'h00, 1'b1);
    got.delete();
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, (i % 2 == 0) ? 5'h01 : 5'h02, 1'b1);
    for (int i = 0; i < 4; i++)  cyc(1'b0, 1'b1, 5'h02, 1'b1);
    expq.delete();
    for (int i = 0; i < 20; i++) expq.push_back((i % 2 == 0) ? 8'h01 : 8'h02);
    check_got("alternate");

    // Stalled FIFO with toggling probe: fifth sample dropped.
    cyc(1'b1, 1'b0, 5'h00, 1'b0);
    got.delete();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, (i % 2 == 0) ? 5'h01 : 5'h02, 1'b0);
    chk("stall_ovf_set", 32'(overflow), 32'h1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 5'h09, 1'b1);
    expq = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h09};
    check_got("stall");
    chk("stall_ovf_sticky", 32'(overflow), 32'h1);

    // Enable drop mid-run discards the pending run.
    cyc(1'b1, 1'b0, 5'h00, 1'b1);
    got.delete();
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 5'h07, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 5'h07, 1'b1);
    for (int i = 0; i < 5; i++)  cyc(1'b0, 1'b1, 5'h07, 1'b1);
    expq = '{8'h07, 8'h07};
    check_got("enable_gap");

    // Reset with bytes queued and overflow set.
    cyc(1'b1, 1'b0, 5'h00, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, (i % 2 == 0) ? 5'h01 : 5'h02, 1'b0);
    chk("pre_reset_ovf", 32'(overflow), 32'h1);
    cyc(1'b1, 1'b1, 5'h0A, 1'b0);
    got.delete();
    reset = 1'b0; enable = 1'b1; probe = 5'h0A; fifo_ready = 1'b1;
    #1;
    chk("post_reset_write", 32'(out_write), 32'h0);
    chk("post_reset_ovf",   32'(overflow),  32'h0);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 5'h0A, 1'b1);
    expq = '{8'h0A};
    check_got("post_reset");

    // Randomized traffic in phases with different change/ready behaviour.
    begin
      int          chg[4] = '{2, 6, 400, 1500};
      int          rdy_pct[4] = '{50, 90, 100, 35};
      logic [PW-1:0] p;
      logic        e;
      logic        y;
      logic        r;
      p = 5'h00;
      for (int ph = 0; ph < 4; ph++) begin
        for (int i = 0; i < 1500; i++) begin
          if ($urandom_range(0, chg[ph] - 1) == 0) p = PW'($urandom_range(0, 31));
          e = ($urandom_range(0, 199) != 0);
          y = ($urandom_range(0, 99) < rdy_pct[ph]);
          r = ($urandom_range(0, 999) == 0);
          cyc(r, e, p, y);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/probe_rle_encoder.md
# probe_rle_encoder

Run-length compressor for the saxoscope probe stream. It sits between the two-stage probe synchronizer and the FX2 FIFO4 write port. It replaces the raw one-byte-per-clock dump with a byte stream that records each change of the probe inputs plus the run length between changes. A short internal queue absorbs double-byte bursts and momentary FIFO-full stalls. Losses are flagged on the board error LED.

## Interface

Parameters:
- `PROBE_WIDTH`, default 5: number of probe bits (ACK, CLK, SEL, CMD, DAT); must be ≤ 7.
- `QUEUE_LOG2`, default 2: log2 of internal queue depth (4 entries); must be ≥ 1.

Ports:
- `clk`  in  1: FIFO_clk domain; the block's only clock.
- `reset`  in  1: synchronous, active-high; all state cleared on the clk edge where it is high.
- `enable`  in  1: capture enable; when low, no new bytes are generated and run state is held cleared.
- `probe`  in  PROBE_WIDTH: already-synchronized probe sample, taken every clk.
- `fifo_ready`  in  1: FIFO4_ready_to_accept_data (active-high, not full).
- `out_data`  out  8: byte presented to FIFO4; equals the queue head, and is 8'h00 when the queue is empty.
- `out_write`  out  1: combinational `fifo_ready & ~queue_empty`; a byte is consumed on every clk where it is high.
- `overflow`  out  1: sticky error flag; set on any dropped byte, cleared only by reset.

## Operation

Byte format:
- Sample byte: bit7 = 0, bits[6:PROBE_WIDTH] = 0, low bits = probe value.
- Run byte: bit7 = 1, bits[6:0] = n with 1 ≤ n ≤ 127. It means the previous sample held for n further clocks.

Registers:
- `last`: PROBE_WIDTH bits.
- `count`: 7 bits.
- `force`: 1 bit. Reset value is 1, so the first enabled cycle always emits a sample byte.

Per enabled clk, in priority order:
- `force` = 1: push sample(probe); `last` ← probe; `count` ← 0; `force` ← 0.
- probe ≠ `last`, `count` > 0: push run(count), then sample(probe), both in the same cycle, run byte first. `last` ← probe; `count` ← 0.
- probe ≠ `last`, `count` = 0: push sample(probe); `last` ← probe.
- probe = `last`, `count` = 126: push run(127), i.e. 8'hFF; `count` ← 0.
- probe = `last`, otherwise: `count` ← `count` + 1, with no push.

Enable and overflow rules:
- `enable` low: no pushes; `force` ← 1 and `count` ← 0. Any pending run is discarded, and draining of the queue continues.
- The queue accepts 0, 1 or 2 pushes and 1 pop per clk.
- Free slots are computed after counting that cycle's pop.
- Overflow: if the free slots are fewer than the pushes required, the entire group is dropped. Never push half of a run+sample pair. In that cycle:
  - `overflow` ← 1.
  - `force` ← 1.
  - `count` ← 0.
  - The next enabled cycle re-emits the current sample.

## Timing

- Reset values: `out_write` = 0, `out_data` = 8'h00, `overflow` = 0, queue empty, `force` = 1, `count` = 0, `last` = 0.
- Latency: a probe change sampled at edge t is pushed at edge t+1. The sample byte is at the queue head and `out_write` can be high in the cycle after t+1, provided the queue was empty and `fifo_ready` is high.
- A run+sample pair leaves the queue on two consecutive writes, at the earliest.
- Simultaneous pop and push when full: the pop frees a slot, so a single push is accepted.
- `reset` mid-stream empties the queue immediately. `out_write` is low in the cycle after the reset edge. No partial byte is ever emitted.
- Run counting has no wrap: `count` never exceeds 126 in the register.

## Structure

- Package `probe_rle_pkg`:
  - `RUN_FLAG` = 8'h80.
  - `MAX_RUN` = 7'd127.
  - Helper functions `mk_sample(value)` and `mk_run(n)`.
- Sub-module `byte_queue`:
  - 2^QUEUE_LOG2 × 8 circular buffer with dual-push (ordered) and single-pop.
  - Outputs head, empty and a free-slot count.
  - Read and write pointers are QUEUE_LOG2+1 bits wide, for full/empty discrimination.
- Top level holds the encoder FSM registers and the overflow flag.

## Test plan

- After reset, `enable` = 1, `fifo_ready` = 1, probe = 5'h03 held for 300 clks, then probe = 5'h04:
  - Bytes out: 8'h03, 8'hFF, 8'hFF, 8'hAD, 8'h04.
  - `overflow` stays 0.
- Probe alternates 5'h01 / 5'h02 every clk for 20 clks → 20 sample bytes alternating 8'h01 / 8'h02, with no run bytes.
- Probe = 5'h05 for 4 clks, then 5'h06; `fifo_ready` = 0 throughout:
  - Queue reaches 3 entries (05, run 03, 06).
  - Raising `fifo_ready` drains exactly 8'h05, 8'h83, 8'h06.
- `fifo_ready` held 0 while probe toggles every clk:
  - The fifth sample is dropped and `overflow` goes 1.
  - After `fifo_ready` = 1, the queued 4 bytes come out first, followed by a sample byte of the current probe value.
- `enable` dropped for 10 clks in the middle of a run of 5'h07, then raised with probe still 5'h07:
  - The pending run is discarded.
  - The next byte is 8'h07.
- `reset` asserted with 3 bytes queued:
  - `out_write` = 0 on the following clk and `overflow` = 0.
  - The first byte after reset release is a sample byte.
